cnt_mod16_s_axi: RTL

AXI4-Lite responder for the CNT_MOD16 peripheral: six 32-bit registers controlling a prescaled 4-bit modulo-16 up/down counter. The block sits behind the AXI VIP master / PS interconnect as the S00_AXI slave. It exports the count and a wrap pulse to fabric logic.

---
 rtl/cnt_mod16_s_axi.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/cnt_mod16_s_axi.sv
// AXI4-Lite slave for the CNT_MOD16 peripheral: six registers around a
// prescaled 4-bit up/down counter that also drives cnt_o/wrap_o to the fabric.
`timescale 1ns/1ps
module cnt_mod16_s_axi #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5
) (
  input  logic                              S_AXI_ACLK,
  input  logic                              S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  output logic [3:0]                        cnt_o,
  output logic                              wrap_o
);

  logic        aw_full, w_full, bvalid, rvalid;
  logic [2:0]  aw_idx;
  logic [31:0] w_data;
  logic [3:0]  w_strb;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;

  logic [31:0] ctrl_reg, load_reg, psc_reg, scratch_reg, wraps_reg, psc_cnt;
  logic [3:0]  count_reg;
  logic        wrap_reg;

  logic [31:0] byte_mask;
  logic        commit, wr_err, load_stb, clear_stb;
  logic        en, dir, tick, wrap_evt;
  logic [3:0]  count_step;
  logic [31:0] rd_data;
  logic        rd_err;

  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign S_AXI_AWREADY = !aw_full && !bvalid;
  assign S_AXI_WREADY  = !w_full && !bvalid;
  assign S_AXI_BVALID  = bvalid;
  assign S_AXI_BRESP   = bresp;
  assign S_AXI_ARREADY = !rvalid;
  assign S_AXI_RVALID  = rvalid;
  assign S_AXI_RDATA   = rdata;
  assign S_AXI_RRESP   = rresp;
  assign cnt_o         = count_reg;
  assign wrap_o        = wrap_reg;

  for (genvar gi = 0; gi < 4; gi++) begin : g_mask
    assign byte_mask[8*gi +: 8] = {8{w_strb[gi]}};
  end

  assign commit    = aw_full && w_full;
  assign wr_err    = aw_idx[2];
  assign load_stb  = commit && (aw_idx == 3'd0) && w_strb[0] && w_data[2];
  assign clear_stb = commit && (aw_idx == 3'd0) && w_strb[0] && w_data[3];

  assign en         = ctrl_reg[0];
  assign dir        = ctrl_reg[1];
  assign tick       = en && (psc_cnt >= psc_reg);
  assign count_step = dir ? count_reg - 4'd1 : count_reg + 4'd1;
  assign wrap_evt   = tick && (dir ? (count_reg == 4'd0) : (count_reg == 4'd15));

  always_comb begin
    rd_data = '0;
    rd_err  = 1'b0;
    case (S_AXI_ARADDR[4:2])
      3'd0:    rd_data = ctrl_reg;
      3'd1:    rd_data = load_reg;
      3'd2:    rd_data = psc_reg;
      3'd3:    rd_data = scratch_reg;
      3'd4:    rd_data = {28'd0, count_reg};
      3'd5:    rd_data = wraps_reg;
      default: rd_err  = 1'b1;
    endcase
  end

  // AW and W buffer independently; the commit empties both and raises B.
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      aw_full <= 1'b0;
      w_full  <= 1'b0;
      aw_idx  <= '0;
      w_data  <= '0;
      w_strb  <= '0;
      bvalid  <= 1'b0;
      bresp   <= 2'b00;
    end else begin
      if (S_AXI_AWVALID && S_AXI_AWREADY) begin
        aw_full <= 1'b1;
        aw_idx  <= S_AXI_AWADDR[4:2];
      end
      if (S_AXI_WVALID && S_AXI_WREADY) begin
        w_full <= 1'b1;
        w_data <= S_AXI_WDATA;
        w_strb <= S_AXI_WSTRB;
      end
      if (commit) begin
        aw_full <= 1'b0;
        w_full  <= 1'b0;
        bvalid  <= 1'b1;
        bresp   <= wr_err ? 2'b10 : 2'b00;
      end else if (bvalid && S_AXI_BREADY) begin
        bvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      ctrl_reg    <= '0;
      load_reg    <= '0;
      psc_reg     <= '0;
      scratch_reg <= '0;
    end else if (commit) begin
      case (aw_idx)
        3'd0: ctrl_reg    <= ((ctrl_reg & ~byte_mask) | (w_data & byte_mask)) & ~32'hC;
        3'd1: load_reg    <= (load_reg & ~byte_mask) | (w_data & byte_mask);
        3'd2: psc_reg     <= (psc_reg & ~byte_mask) | (w_data & byte_mask);
        3'd3: scratch_reg <= (scratch_reg & ~byte_mask) | (w_data & byte_mask);
        default: ;
      endcase
    end
  end

  // CLEAR beats LOAD beats the prescaler tick; ctrl_reg here is the pre-commit value.
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      count_reg <= '0;
      psc_cnt   <= '0;
      wraps_reg <= '0;
      wrap_reg  <= 1'b0;
    end else begin
      wrap_reg <= 1'b0;
      if (clear_stb) begin
        count_reg <= '0;
        psc_cnt   <= '0;
        wraps_reg <= '0;
      end else if (load_stb) begin
        count_reg <= load_reg[3:0];
        psc_cnt   <= '0;
      end else if (tick) begin
        psc_cnt   <= '0;
        count_reg <= count_step;
        if (wrap_evt) begin
          wrap_reg  <= 1'b1;
          wraps_reg <= wraps_reg + 32'd1;
        end
      end else if (en) begin
        psc_cnt <= psc_cnt + 32'd1;
      end
    end
  end

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      rvalid <= 1'b0;
      rdata  <= '0;
      rresp  <= 2'b00;
    end else if (S_AXI_ARVALID && S_AXI_ARREADY) begin
      rvalid <= 1'b1;
      rdata  <= rd_data;
      rresp  <= rd_err ? 2'b10 : 2'b00;
    end else if (rvalid && S_AXI_RREADY) begin
      rvalid <= 1'b0;
    end
  end

endmodule
